crc_serial_rx: RTL and testbench

Bit-serial CRC receiver and checker: the receiving end of the serial link that carries `crcEncode` codewords. It accepts one codeword bit per handshake, MSB first (big-endian), computes the division remainder on the fly, then presents the recovered data word, the syndrome and an error flag on a held output. A cumulative error counter gives the bench and `checker` a frame-level error view alongside the combinational `crcDecode`.

---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc_serial_lfsr.sv | 42 ++++
 rtl/crc_serial_rx.sv | 137 +++++++++++++
 tb/tb_crc_serial_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// crc_pkg
// Shared definitions for the serial CRC link: default frame geometry,
// the generator polynomial and the receiver state encoding.
//   CRC_N   - data bits per frame
//   CRC_R   - generator width in bits (remainder is CRC_R-1 bits)
//   CRC_DIV - generator polynomial, MSB = x^(CRC_R-1), LSB must be 1
//   CRC_W   - codeword width, data followed by remainder
package crc_pkg;

    localparam int CRC_N = 16;
    localparam int CRC_R = 7;
    localparam logic [CRC_R-1:0] CRC_DIV = 7'b1111011;
    localparam int CRC_W = CRC_N + CRC_R - 1;

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } rxStateT;

endpackage

// File: rtl/crc_serial_lfsr.sv
// crc_serial_lfsr
// Bit-serial polynomial division register. Each enabled cycle shifts one
// codeword bit in (MSB first) and reduces by the generator, so after the
// whole codeword has passed, rem holds codeword mod generator.
// Ports:
//   clk   in   clock, rising edge
//   reset in   asynchronous active-low reset, clears rem
//   clr   in   synchronous clear, wins over en
//   en    in   shift din in this cycle
//   din   in   next codeword bit
//   rem   out  running remainder, R-1 bits
module crc_serial_lfsr
    import crc_pkg::*;
#(
    parameter int R = CRC_R,
    parameter logic [R-1:0] DIV = CRC_DIV
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [R-2:0] rem
);

    logic [R-2:0] remStep;

    // Subtract the generator whenever the bit leaving the top is set; the
    // x^(R-1) term of DIV cancels that bit, so only DIV[R-2:0] is applied.
    assign remStep = {rem[R-3:0], din} ^ (rem[R-2] ? DIV[R-2:0] : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= '0;
        end else if (clr) begin
            rem <= '0;
        end else if (en) begin
            rem <= remStep;
        end
    end

endmodule

// File: rtl/crc_serial_rx.sv
// crc_serial_rx
// Bit-serial CRC receiver. Accepts one codeword bit per handshake, MSB
// first, divides on the fly and presents the recovered data word, the
// syndrome and an error flag on a held output until the consumer takes it.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   clear      in   synchronous frame abort, drops any partial/held frame
//   in_valid   in   in_bit valid this cycle
//   in_ready   out  receiver accepts a bit (RECV state)
//   in_bit     in   next codeword bit, MSB first
//   out_valid  out  completed frame held on outputs (HOLD state)
//   out_ready  in   consumer accepts the held frame
//   out_data   out  data part of the codeword, N bits
//   syndrome   out  codeword mod generator, R-1 bits
//   crc_error  out  syndrome is non-zero
//   err_count  out  saturating count of delivered erroneous frames
module crc_serial_rx
    import crc_pkg::*;
#(
    parameter int N = CRC_N,
    parameter int R = CRC_R,
    parameter logic [R-1:0] DIV = CRC_DIV
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [R-2:0] syndrome,
    output logic         crc_error,
    output logic [15:0]  err_count
);

    localparam int W  = N + R - 1;
    localparam int CW = $clog2(W);

    rxStateT      state, stateNext;
    logic [CW-1:0] bitCnt;
    logic [W-2:0]  shiftReg;
    logic [R-2:0]  rem;
    logic [R-2:0]  remFinal;
    logic [N-1:0]  dataReg;
    logic [R-2:0]  synReg;
    logic [15:0]   errCount;
    logic          accept;
    logic          lastBit;
    logic          outFire;

    // Decoded from the state register rather than in_ready to keep the
    // handshake free of a combinational loop through the FSM block.
    assign accept  = in_valid && (state == RECV);
    assign lastBit = accept && (bitCnt == CW'(W - 1));
    assign outFire = (state == HOLD) && out_ready;

    // The remainder register is cleared on the final bit, so the value it
    // would have taken is recomputed here to capture the syndrome.
    assign remFinal = {rem[R-3:0], in_bit} ^ (rem[R-2] ? DIV[R-2:0] : '0);

    crc_serial_lfsr #(
        .R   (R),
        .DIV (DIV)
    ) uLfsr (
        .clk   (clk),
        .reset (reset),
        .clr   (clear | lastBit),
        .en    (accept),
        .din   (in_bit),
        .rem   (rem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RECV;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            RECV: begin
                in_ready = 1'b1;
                if (lastBit) stateNext = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) stateNext = RECV;
            end
            default: stateNext = RECV;
        endcase
        if (clear) stateNext = RECV;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitCnt   <= '0;
            shiftReg <= '0;
            dataReg  <= '0;
            synReg   <= '0;
            errCount <= '0;
        end else if (clear) begin
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            if (accept) begin
                if (lastBit) begin
                    // shiftReg[k] holds codeword bit k+1, so the data field
                    // [W-1:R-1] sits at [W-2:R-2]; the last bit is CRC only.
                    bitCnt   <= '0;
                    shiftReg <= '0;
                    dataReg  <= shiftReg[W-2:R-2];
                    synReg   <= remFinal;
                end else begin
                    bitCnt   <= bitCnt + 1'b1;
                    shiftReg <= {shiftReg[W-3:0], in_bit};
                end
            end
            if (outFire && crc_error && (errCount != 16'hFFFF)) begin
                errCount <= errCount + 16'd1;
            end
        end
    end

    assign out_data  = dataReg;
    assign syndrome  = synReg;
    assign crc_error = |synReg;
    assign err_count = errCount;

endmodule

// File: tb/tb_crc_serial_rx.sv
// tb_crc_serial_rx
// Directed bench for crc_serial_rx with the default 16-bit data / 7-bit
// generator (0x7B) configuration.
module tb_crc_serial_rx;
    import crc_pkg::*;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  syndrome;
    logic        crc_error;
    logic [15:0] err_count;

    int nAsserts = 0;
    int nFail    = 0;

    crc_serial_rx dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .syndrome  (syndrome),
        .crc_error (crc_error),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send bits cw[hi] down to cw[lo], optionally with random idle gaps.
    task automatic sendBits(input logic [21:0] cw, input int hi, input int lo, input bit gaps);
        for (int i = hi; i >= lo; i--) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                for (int k = 0; k < g; k++) tick();
            end
            in_valid = 1'b1;
            in_bit   = cw[i];
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic sendFrame(input logic [21:0] cw, input bit gaps);
        sendBits(cw, CRC_W - 1, 1, gaps);
        check("notYetValid", {31'd0, out_valid}, 32'd0);
        sendBits(cw, 0, 0, gaps);
    endtask

    task automatic expectFrame(input string tag, input logic [15:0] d, input logic [5:0] s,
                               input logic e);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
        check({tag, "_syn"}, {26'd0, syndrome}, {26'd0, s});
        check({tag, "_err"}, {31'd0, crc_error}, {31'd0, e});
    endtask

    task automatic handshake(input string tag, input logic [15:0] cnt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_relValid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_relReady"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_cnt"}, {16'd0, err_count}, {16'd0, cnt});
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        #22;
        check("rst_inReady", {31'd0, in_ready}, 32'd1);
        check("rst_outValid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_syn", {26'd0, syndrome}, 32'd0);
        check("rst_err", {31'd0, crc_error}, 32'd0);
        check("rst_cnt", {16'd0, err_count}, 32'd0);
        reset = 1'b1;
        tick();

        // Clean and single-bit-error frames
        sendFrame(22'h000000, 1'b0);
        expectFrame("zero", 16'h0000, 6'h00, 1'b0);
        handshake("zero", 16'd0);

        sendFrame(22'h00007B, 1'b0);
        expectFrame("good1", 16'h0001, 6'h00, 1'b0);
        handshake("good1", 16'd0);

        sendFrame(22'h00007A, 1'b0);
        expectFrame("err7A", 16'h0001, 6'h01, 1'b1);
        handshake("err7A", 16'd1);

        sendFrame(22'h00003B, 1'b0);
        expectFrame("err3B", 16'h0000, 6'h3B, 1'b1);
        handshake("err3B", 16'd2);

        // Input gaps and output backpressure; in_bit wiggles while held
        sendFrame(22'h00007A, 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_bit   = k[0];
            tick();
            expectFrame("hold", 16'h0001, 6'h01, 1'b1);
            check("holdCnt", {16'd0, err_count}, 32'd2);
        end
        in_valid = 1'b0;
        handshake("hold", 16'd3);
        sendFrame(22'h00007B, 1'b1);
        expectFrame("afterHold", 16'h0001, 6'h00, 1'b0);
        handshake("afterHold", 16'd3);

        // Abort a partial frame, then a clean frame
        sendBits(22'h3FFFFF, 21, 12, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sendFrame(22'h00007B, 1'b0);
        expectFrame("afterClr", 16'h0001, 6'h00, 1'b0);
        handshake("afterClr", 16'd3);

        // Clear while holding an erroneous frame drops it uncounted
        sendFrame(22'h00007A, 1'b0);
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        check("clrHold_valid", {31'd0, out_valid}, 32'd0);
        check("clrHold_ready", {31'd0, in_ready}, 32'd1);
        check("clrHold_cnt", {16'd0, err_count}, 32'd3);

        // Asynchronous reset mid-frame
        sendBits(22'h00007A, 21, 14, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("midRst_inReady", {31'd0, in_ready}, 32'd1);
        check("midRst_outValid", {31'd0, out_valid}, 32'd0);
        check("midRst_data", {16'd0, out_data}, 32'd0);
        check("midRst_syn", {26'd0, syndrome}, 32'd0);
        check("midRst_err", {31'd0, crc_error}, 32'd0);
        check("midRst_cnt", {16'd0, err_count}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        sendFrame(22'h00007B, 1'b0);
        expectFrame("afterRst", 16'h0001, 6'h00, 1'b0);
        handshake("afterRst", 16'd0);

        // Counter saturation, preloaded to one below the ceiling
        force dut.errCount = 16'hFFFE;
        tick();
        release dut.errCount;
        tick();
        check("preload", {16'd0, err_count}, 32'h0000FFFE);
        sendFrame(22'h00007A, 1'b0);
        expectFrame("sat1", 16'h0001, 6'h01, 1'b1);
        handshake("sat1", 16'hFFFF);
        sendFrame(22'h00003B, 1'b0);
        expectFrame("sat2", 16'h0000, 6'h3B, 1'b1);
        handshake("sat2", 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
